// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : parametrised multi-cycle ALU with valid/ready handshakes.
//
// The opcode encoding is the same 4-bit alu_control used by the older
// combinational datapath ALU. SLTU, SRA, DIVU and REMU are new opcodes,
// and the ALU now also reports carry and overflow flags.
// MUL, DIVU and REMU produce one bit per cycle. Every other opcode finishes
// in a single cycle.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   in_valid       operands/opcode valid
//   in_ready       ALU can accept (high only in IDLE)
//   in1, in2       operands A and B (WIDTH bits)
//   alu_control    4-bit opcode
//   out_valid      result and flags valid (DONE state)
//   out_ready      consumer accepts the result
//   alu_result     registered result (WIDTH bits)
//   zero_flag      alu_result == 0
//   carry_flag     ADD carry-out / SUB not-borrow, else 0
//   overflow_flag  ADD/SUB signed overflow, else 0
//   busy           high while an iterative op is running
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [3:0]       op_code;
    logic [SHW-1:0]   count;

    // Iterative datapath registers: the multiplier uses acc/mcand/mplier,
    // the divider uses rem/quot/divisor. quot starts out holding the dividend
    // and receives quotient bits from the bottom as the dividend bits are
    // shifted out of the top.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_ovf;
    logic             is_multi;

    logic [WIDTH-1:0] mul_next;
    logic [WIDTH:0]   rem_shift;
    logic             div_fits;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] mc_result;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    // Single-cycle ops are evaluated straight from the inputs and latched on
    // the accept edge. SUB is computed as in1 + ~in2 + 1, so its carry-out
    // reads directly as "no borrow".
    always_comb begin
        shamt     = in2[SHW-1:0];
        sum_ext   = {1'b0, in1} + {1'b0, in2};
        diff_ext  = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        is_multi  = (alu_control == OP_MUL) || (alu_control == OP_DIVU) ||
                    (alu_control == OP_REMU);
        case (alu_control)
            OP_AND:  sc_result = in1 & in2;
            OP_OR:   sc_result = in1 | in2;
            OP_XOR:  sc_result = in1 ^ in2;
            OP_ADD: begin
                sc_result = sum_ext[WIDTH-1:0];
                sc_carry  = sum_ext[WIDTH];
                sc_ovf    = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff_ext[WIDTH-1:0];
                sc_carry  = diff_ext[WIDTH];
                sc_ovf    = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_SLL:  sc_result = in1 << shamt;
            OP_SRL:  sc_result = in1 >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(in1) >>> shamt);
            default: sc_result = '0;
        endcase
    end

    // One iteration step. Restoring division: shift the next dividend bit
    // into the remainder and subtract the divisor if it fits. A zero divisor
    // always fits, which gives all-ones quotient and remainder == dividend.
    always_comb begin
        mul_next  = mplier[0] ? (acc + mcand) : acc;
        rem_shift = (rem << 1) | {{WIDTH{1'b0}}, quot[WIDTH-1]};
        div_fits  = (rem_shift >= {1'b0, divisor});
        rem_next  = div_fits ? (rem_shift - {1'b0, divisor}) : rem_shift;
        quot_next = {quot[WIDTH-2:0], div_fits};
        case (op_code)
            OP_MUL:  mc_result = mul_next;
            OP_DIVU: mc_result = quot_next;
            default: mc_result = rem_next[WIDTH-1:0];
        endcase
    end

    // Control FSM plus result/flag registers. The result is written only on
    // entry to DONE, so it stays put under any amount of backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_code       <= '0;
            count         <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            quot          <= '0;
            divisor       <= '0;
            rem           <= '0;
            alu_result    <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_multi) begin
                            op_code <= alu_control;
                            count   <= '0;
                            acc     <= '0;
                            mcand   <= in1;
                            mplier  <= in2;
                            quot    <= in1;
                            divisor <= in2;
                            rem     <= '0;
                            state   <= BUSY;
                        end else begin
                            alu_result    <= sc_result;
                            zero_flag     <= (sc_result == '0);
                            carry_flag    <= sc_carry;
                            overflow_flag <= sc_ovf;
                            state         <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    rem    <= rem_next;
                    quot   <= quot_next;
                    count  <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        count         <= '0;
                        alu_result    <= mc_result;
                        zero_flag     <= (mc_result == '0);
                        carry_flag    <= 1'b0;
                        overflow_flag <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
